// File: rtl/ts_gen_ml.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ts_gen_ml                                                       |
// | Purpose  : Multi-lane TS1/TS2 ordered-set generator with valid/ready output |
// |            and update/ack/stop control. Macro TS_GEN_SKP_EN inserts SKP     |
// |            beats every SKP_INTERVAL accepted TS beats.                      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ts_gen_ml #(
    parameter int         LANES        = 4,
    parameter int         CNT_W        = 16,
    parameter logic [5:0] RATE_SUPPORT = 6'b000010,
    parameter int         SKP_INTERVAL = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_ts_type,
    input  logic [7:0]           cfg_link_num,
    input  logic                 cfg_link_pad,
    input  logic                 cfg_lane_pad,
    input  logic [7:0]           cfg_n_fts,
    input  logic [7:0]           cfg_train_ctrl,
    input  logic [CNT_W-1:0]     cfg_target,
    input  logic                 ts_update,
    output logic                 ts_update_ack,
    input  logic                 ts_stop,
    output logic [CNT_W-1:0]     ts_sent_cnt,
    output logic                 ts_sent_enough,
    output logic                 ts_valid,
    input  logic                 ts_ready,
    output logic [LANES*128-1:0] ts
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

`ifdef TS_GEN_SKP_EN
    localparam bit SKP_EN = 1'b1;
`else
    localparam bit SKP_EN = 1'b0;
`endif

    localparam int                   SKP_CW   = $clog2(SKP_INTERVAL + 1);
    localparam logic [SKP_CW-1:0]    SKP_LAST = SKP_CW'(SKP_INTERVAL - 1);
    localparam logic [LANES*128-1:0] SKP_BEAT = {LANES{8'hBC, {15{8'h1C}}}};

    function automatic logic [LANES*128-1:0] build_ts(
        input logic       ts2,
        input logic [7:0] link_num,
        input logic       link_pad,
        input logic       lane_pad,
        input logic [7:0] n_fts,
        input logic [7:0] train_ctrl
    );
        logic [LANES*128-1:0] beat;
        logic [7:0]           fill;
        beat = '0;
        fill = ts2 ? 8'h45 : 8'h4A;
        for (int l = 0; l < LANES; l++) begin
            beat[128*l +: 128] = {8'hBC,
                                  link_pad ? 8'hF7 : link_num,
                                  lane_pad ? 8'hF7 : 8'(l),
                                  n_fts,
                                  {2'b00, RATE_SUPPORT},
                                  train_ctrl,
                                  {10{fill}}};
        end
        return beat;
    endfunction

    state_t               state_q, state_d;
    logic                 ack_q, ack_d;
    logic                 valid_q, valid_d;
    logic                 enough_q, enough_d;
    logic                 loaded_q, loaded_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     target_q, target_d;
    logic                 ts_type_q, ts_type_d;
    logic [7:0]           link_num_q, link_num_d;
    logic                 link_pad_q, link_pad_d;
    logic                 lane_pad_q, lane_pad_d;
    logic [7:0]           n_fts_q, n_fts_d;
    logic [7:0]           train_ctrl_q, train_ctrl_d;
    logic [SKP_CW-1:0]    skp_cnt_q, skp_cnt_d;
    logic                 skp_pend_q, skp_pend_d;
    logic [LANES*128-1:0] ts_q, ts_d;

    logic stalled;
    logic xfer;
    logic update_req;
    logic stop_now;
    logic load;

    always_comb begin
        stalled    = valid_q & ~ts_ready;
        xfer       = valid_q & ts_ready;
        // An update seen while ack is still high is the tail of the request just served.
        update_req = ts_update & ~ack_q;
        stop_now   = (state_q == ST_SEND) & ts_stop & ~stalled;
        load       = update_req & ~stop_now & ((state_q == ST_IDLE) | ~stalled);

        state_d      = state_q;
        ack_d        = 1'b0;
        valid_d      = valid_q;
        loaded_d     = loaded_q;
        cnt_d        = cnt_q;
        target_d     = target_q;
        ts_type_d    = ts_type_q;
        link_num_d   = link_num_q;
        link_pad_d   = link_pad_q;
        lane_pad_d   = lane_pad_q;
        n_fts_d      = n_fts_q;
        train_ctrl_d = train_ctrl_q;
        skp_cnt_d    = skp_cnt_q;
        skp_pend_d   = skp_pend_q;
        ts_d         = ts_q;
        enough_d     = loaded_q & (enough_q | (cnt_q >= target_q));

        if (xfer) begin
            if (skp_pend_q) begin
                skp_pend_d = 1'b0;
                ts_d       = build_ts(ts_type_q, link_num_q, link_pad_q, lane_pad_q,
                                      n_fts_q, train_ctrl_q);
            end else begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (SKP_EN && (skp_cnt_q == SKP_LAST)) begin
                    skp_cnt_d  = '0;
                    skp_pend_d = 1'b1;
                    ts_d       = SKP_BEAT;
                end else begin
                    skp_cnt_d = skp_cnt_q + 1'b1;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
            end
            ST_SEND: begin
                if (stop_now) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (load) begin
            state_d      = ST_SEND;
            ack_d        = 1'b1;
            valid_d      = 1'b1;
            loaded_d     = 1'b1;
            cnt_d        = '0;
            enough_d     = 1'b0;
            target_d     = cfg_target;
            ts_type_d    = cfg_ts_type;
            link_num_d   = cfg_link_num;
            link_pad_d   = cfg_link_pad;
            lane_pad_d   = cfg_lane_pad;
            n_fts_d      = cfg_n_fts;
            train_ctrl_d = cfg_train_ctrl;
            skp_cnt_d    = '0;
            skp_pend_d   = 1'b0;
            ts_d         = build_ts(cfg_ts_type, cfg_link_num, cfg_link_pad, cfg_lane_pad,
                                    cfg_n_fts, cfg_train_ctrl);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ack_q        <= 1'b0;
            valid_q      <= 1'b0;
            enough_q     <= 1'b0;
            loaded_q     <= 1'b0;
            cnt_q        <= '0;
            target_q     <= '0;
            ts_type_q    <= 1'b0;
            link_num_q   <= '0;
            link_pad_q   <= 1'b0;
            lane_pad_q   <= 1'b0;
            n_fts_q      <= '0;
            train_ctrl_q <= '0;
            skp_cnt_q    <= '0;
            skp_pend_q   <= 1'b0;
            ts_q         <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            valid_q      <= valid_d;
            enough_q     <= enough_d;
            loaded_q     <= loaded_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            ts_type_q    <= ts_type_d;
            link_num_q   <= link_num_d;
            link_pad_q   <= link_pad_d;
            lane_pad_q   <= lane_pad_d;
            n_fts_q      <= n_fts_d;
            train_ctrl_q <= train_ctrl_d;
            skp_cnt_q    <= skp_cnt_d;
            skp_pend_q   <= skp_pend_d;
            ts_q         <= ts_d;
        end
    end

    assign ts_update_ack  = ack_q;
    assign ts_valid       = valid_q;
    assign ts_sent_cnt    = cnt_q;
    assign ts_sent_enough = enough_q;
    assign ts             = ts_q;

endmodule
`default_nettype wire

// File: tb/tb_ts_gen_ml.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ts_gen_ml                                                    |
// | Purpose  : Scoreboard bench for ts_gen_ml (honours TS_GEN_SKP_EN).          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ts_gen_ml;
    localparam int         LANES        = 4;
    localparam int         CNT_W        = 16;
    localparam int         SKP_INTERVAL = 8;
    localparam logic [5:0] RATE         = 6'b000010;
    localparam int         W            = LANES * 128;
`ifdef TS_GEN_SKP_EN
    localparam int SAT_CYCLES = 65535 + 65535 / SKP_INTERVAL + 16;
`else
    localparam int SAT_CYCLES = 65535 + 16;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_ts_type, cfg_link_pad, cfg_lane_pad;
    logic [7:0]       cfg_link_num, cfg_n_fts, cfg_train_ctrl;
    logic [CNT_W-1:0] cfg_target;
    logic             ts_update, ts_update_ack, ts_stop;
    logic [CNT_W-1:0] ts_sent_cnt;
    logic             ts_sent_enough, ts_valid, ts_ready;
    logic [W-1:0]     ts;

    always #5 clk = ~clk;

    ts_gen_ml #(
        .LANES(LANES), .CNT_W(CNT_W), .RATE_SUPPORT(RATE), .SKP_INTERVAL(SKP_INTERVAL)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_ts_type(cfg_ts_type), .cfg_link_num(cfg_link_num),
        .cfg_link_pad(cfg_link_pad), .cfg_lane_pad(cfg_lane_pad),
        .cfg_n_fts(cfg_n_fts), .cfg_train_ctrl(cfg_train_ctrl), .cfg_target(cfg_target),
        .ts_update(ts_update), .ts_update_ack(ts_update_ack), .ts_stop(ts_stop),
        .ts_sent_cnt(ts_sent_cnt), .ts_sent_enough(ts_sent_enough),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts(ts)
    );

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] exp_q[$];

    // Reference model of the generator as seen at the ports.
    logic             m_valid, m_ack, m_skp, m_loaded, m_enough;
    logic [CNT_W-1:0] m_cnt, m_tgt;
    int               m_since;
    logic [W-1:0]     m_pay;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] exp_ts(input logic t2, input logic [7:0] link,
                                            input logic lpad, input logic npad,
                                            input logic [7:0] nfts, input logic [7:0] ctrl);
        logic [W-1:0] v;
        logic [7:0]   s;
        v = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < 16; k++) begin
                case (k)
                    0:       s = 8'hBC;
                    1:       s = lpad ? 8'hF7 : link;
                    2:       s = npad ? 8'hF7 : 8'(l);
                    3:       s = nfts;
                    4:       s = {2'b00, RATE};
                    5:       s = ctrl;
                    default: s = t2 ? 8'h45 : 8'h4A;
                endcase
                v[l*128 + (15-k)*8 +: 8] = s;
            end
        end
        return v;
    endfunction

    function automatic logic [W-1:0] skp_pat();
        logic [W-1:0] v;
        for (int b = 0; b < W / 8; b++) v[b*8 +: 8] = (b % 16 == 15) ? 8'hBC : 8'h1C;
        return v;
    endfunction

    always @(negedge clk) begin
        if (ts_valid) begin
            if (exp_q.size() == 0) check_eq("sb_empty", W'(ts_valid), '0);
            else check_eq("sb_beat", ts, exp_q.pop_front());
        end
    end

    task automatic model_reset();
        m_valid = 0; m_ack = 0; m_skp = 0; m_loaded = 0; m_enough = 0;
        m_cnt = '0; m_tgt = '0; m_since = 0; m_pay = '0;
    endtask

    // Called just after a rising edge: checks this cycle's outputs, drives ready,
    // queues the expected beat and advances the model across the next edge.
    task automatic drive(input logic rdy);
        logic xfer, do_stop, do_load, ne;
        check_eq("ack", W'(ts_update_ack), W'(m_ack));
        check_eq("valid", W'(ts_valid), W'(m_valid));
        check_eq("cnt", W'(ts_sent_cnt), W'(m_cnt));
        check_eq("enough", W'(ts_sent_enough), W'(m_enough));
        ts_ready = rdy;
        if (m_valid) exp_q.push_back(m_skp ? skp_pat() : m_pay);
        xfer    = m_valid && rdy;
        do_stop = m_valid && ts_stop && rdy;
        do_load = ts_update && !m_ack && !do_stop && (!m_valid || rdy);
        ne      = m_loaded && (m_enough || (m_cnt >= m_tgt));
        if (xfer) begin
            if (m_skp) m_skp = 0;
            else begin
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
`ifdef TS_GEN_SKP_EN
                m_since++;
                if (m_since == SKP_INTERVAL) begin m_since = 0; m_skp = 1; end
`endif
            end
        end
        m_enough = ne;
        m_ack    = do_load;
        if (do_stop) m_valid = 0;
        if (do_load) begin
            m_valid = 1; m_cnt = '0; m_enough = 0; m_since = 0; m_skp = 0;
            m_loaded = 1; m_tgt = cfg_target;
            m_pay = exp_ts(cfg_ts_type, cfg_link_num, cfg_link_pad, cfg_lane_pad,
                           cfg_n_fts, cfg_train_ctrl);
        end
        @(posedge clk); #1;
    endtask

    task automatic request(input logic rdy, input int maxc);
        ts_update = 1'b1;
        for (int i = 0; i < maxc; i++) begin
            drive(rdy);
            if (m_ack) break;
        end
        ts_update = 1'b0;
    endtask

    task automatic set_cfg(input logic t2, input logic [7:0] link, input logic lpad,
                           input logic npad, input logic [7:0] nfts, input logic [7:0] ctrl,
                           input logic [CNT_W-1:0] tgt);
        cfg_ts_type = t2; cfg_link_num = link; cfg_link_pad = lpad; cfg_lane_pad = npad;
        cfg_n_fts = nfts; cfg_train_ctrl = ctrl; cfg_target = tgt;
    endtask

    initial begin
        logic [127:0] lane_exp;
        int           acc;
        rst = 1'b1; ts_update = 1'b0; ts_stop = 1'b0; ts_ready = 1'b0;
        set_cfg(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ack", W'(ts_update_ack), '0);
        check_eq("rst_valid", W'(ts_valid), '0);
        check_eq("rst_enough", W'(ts_sent_enough), '0);
        check_eq("rst_cnt", W'(ts_sent_cnt), '0);
        check_eq("rst_ts", ts, '0);
        rst = 1'b0;
        drive(1'b1);

        // TS1 load, then ready toggling toward a target of 16
        set_cfg(1'b0, 8'h05, 1'b0, 1'b0, 8'h20, 8'h00, 16'd16);
        request(1'b1, 10);
        lane_exp = {8'hBC, 8'h05, 8'h02, 8'h20, 8'h02, 8'h00, {10{8'h4A}}};
        check_eq("lane2_ts1", W'(ts[383:256]), W'(lane_exp));
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            if ((i % 2 == 0) && (acc == 8)) begin
`ifdef TS_GEN_SKP_EN
                lane_exp = {8'hBC, {15{8'h1C}}};
`else
                lane_exp = {8'hBC, 8'h05, 8'h00, 8'h20, 8'h02, 8'h00, {10{8'h4A}}};
`endif
                check_eq("beat9_lane0", W'(ts[127:0]), W'(lane_exp));
            end
            if (i % 2 == 0) acc++;
            drive(i % 2 == 0);
        end

        // TS2 update raised while the current beat is stalled
        set_cfg(1'b1, 8'h11, 1'b0, 1'b1, 8'h33, 8'h04, 16'd3);
        ts_update = 1'b1;
        repeat (3) drive(1'b0);
        drive(1'b1);
        drive(1'b1);
        ts_update = 1'b0;
        lane_exp = {8'hBC, 8'h11, 8'hF7, 8'h33, 8'h02, 8'h04, {10{8'h45}}};
        check_eq("lane0_ts2", W'(ts[127:0]), W'(lane_exp));
        repeat (6) drive(1'b1);
        repeat (2) drive(1'b0);

        // Stop and update together: idle one cycle, then reload
        set_cfg(1'b0, 8'h22, 1'b1, 1'b0, 8'h10, 8'h08, 16'd2);
        ts_stop = 1'b1; ts_update = 1'b1;
        drive(1'b1);
        ts_stop = 1'b0;
        drive(1'b1);
        ts_update = 1'b0;
        repeat (4) drive(1'b1);

        // Stop held across a stall, then stop while idle
        ts_stop = 1'b1;
        repeat (2) drive(1'b0);
        drive(1'b1);
        repeat (3) drive(1'b1);
        ts_stop = 1'b0;
        drive(1'b0);

        // Asynchronous reset in the middle of sending, with update pending
        set_cfg(1'b1, 8'h07, 1'b0, 1'b0, 8'h01, 8'h02, 16'd4);
        request(1'b1, 10);
        repeat (5) drive(1'b1);
        ts_update = 1'b1;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", W'(ts_valid), '0);
        check_eq("arst_cnt", W'(ts_sent_cnt), '0);
        check_eq("arst_ts", ts, '0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        request(1'b1, 10);
        repeat (4) drive(1'b1);

        // Counter saturation with continuous ready
        set_cfg(1'b0, 8'h09, 1'b0, 1'b0, 8'h0F, 8'h00, 16'hFFFF);
        request(1'b1, 10);
        for (int i = 0; i < SAT_CYCLES; i++) drive(1'b1);
        check_eq("sat_cnt", W'(ts_sent_cnt), W'(16'hFFFF));
        check_eq("sat_enough", W'(ts_sent_enough), W'(1'b1));

        ts_stop = 1'b1;
        drive(1'b1);
        ts_stop = 1'b0;
        drive(1'b0);
        check_eq("sb_left", W'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
